snn_out_checker: RTL and testbench
==================================

SNN_OUT_CHECKER -- requirements
Module: snn_out_checker

Interface
REQ-001 Parameters (name, default, meaning), SHALL be:
- DATA_W, 13, spike data width
- ADDR_W, 12, spike address width
- DEPTH_R, 21, output map side; N = DEPTH_R*DEPTH_R entries per timestep
- NUM_TS, 2, timesteps checked
- TS_W, 2, timestep tag width
- LAYER_W, 2, layer tag width
- LAYER_ID, 1, layer checked
- CNT_W, 16, counter width
REQ-002 Ports (name, direction, width, meaning), SHALL be:
- clk, in, 1, single clock
- rst_n, in, 1, synchronous active-low reset
- start, in, 1, pulse: clear counters, begin golden load
- gold_valid/gold_ready, in/out, 1/1, golden beat handshake
- gold_ts/gold_addr/gold_data, in, TS_W/ADDR_W/DATA_W, golden beat
- load_done, in, 1, pulse: golden load complete
- hdr_valid/hdr_ready, in/out, 1/1, result header handshake
- hdr_ts/hdr_layer, in, TS_W/LAYER_W, header tags
- spk_valid/spk_ready, in/out, 1/1, spike beat handshake
- spk_addr/spk_data, in, ADDR_W/DATA_W, DUT output beat
- done_in, in, 1, DUT done level
- err_count/dup_count/oob_count, out, CNT_W each, mismatch/duplicate/out-of-range totals
- ts_checked, out, NUM_TS, bit i set once timestep i+1 is fully compared
- mm_valid, out, 1, one-cycle mismatch report pulse
- mm_ts/mm_addr/mm_exp/mm_got, out, TS_W/ADDR_W/DATA_W/DATA_W, mismatch report fields
- finished/pass, out, 1/1, run over / run clean

Function
REQ-003 A beat SHALL transfer on a rising clk edge where valid and ready are both 1; valid is never qualified by ready.
REQ-004 FSM states SHALL be IDLE, LOAD, HDR, CMP, FINAL; ready outputs are asserted only in their own state: gold_ready in LOAD, hdr_ready in HDR, spk_ready in CMP.
REQ-005 Transitions SHALL be: IDLE or FINAL + start -> LOAD; LOAD + load_done -> HDR; HDR + accepted valid header -> CMP; HDR + done_in (no header beat that cycle) -> FINAL; CMP + N-th spike beat -> HDR.
REQ-006 start in LOAD, HDR or CMP SHALL be ignored.
REQ-007 In LOAD, a beat with gold_ts in 1..NUM_TS and gold_addr < N SHALL write gold[gold_ts-1][gold_addr]; any other beat SHALL be dropped and increment oob_count.
REQ-008 load_done coincident with a gold beat SHALL commit that beat, then move to HDR.
REQ-009 A header is valid iff hdr_ts is in 1..NUM_TS and hdr_layer == LAYER_ID; an invalid header SHALL increment oob_count and remain in HDR.
REQ-010 Entering CMP SHALL clear the N-bit seen bitmap and the beat counter, and latch hdr_ts as cur_ts.
REQ-011 Each CMP beat SHALL increment the beat counter and be classified in this priority:
- spk_addr >= N: oob_count+1
- seen[spk_addr] set: dup_count+1
- otherwise set seen[spk_addr]; if spk_data != gold[cur_ts-1][spk_addr], err_count+1
REQ-012 A mismatch SHALL pulse mm_valid for exactly one cycle, the cycle after acceptance, carrying cur_ts, spk_addr, the golden value and spk_data; counter updates SHALL be visible that same cycle.
REQ-013 On the N-th beat, ts_checked[cur_ts-1] SHALL be set; rechecking the same timestep is permitted and re-sets the bit.
REQ-014 All counters SHALL saturate at all-ones.
REQ-015 In FINAL, finished = 1 and pass = (err_count == 0, dup_count == 0, oob_count == 0, ts_checked all ones); both SHALL be 0 in every other state.
REQ-016 start from FINAL SHALL clear the counters, ts_checked and mm_valid, but SHALL keep golden memory contents.

Reset
REQ-017 When rst_n = 0 at a clk edge, the following SHALL be forced to 0: state IDLE, all ready outputs, counters, ts_checked, mm_* outputs, finished, pass, seen bitmap and beat counter; golden memory is not reset.
REQ-018 Reset mid-LOAD or mid-CMP SHALL abandon the transfer; the next start SHALL begin cleanly.

Structure
REQ-019 Package snn_chk_pkg SHALL hold the state enum and parameter defaults.
REQ-020 Golden storage SHALL be sub-module snn_gold_mem: NUM_TS*N words of DATA_W, synchronous write, asynchronous read.

Verification
REQ-021 Load all-zero gold for ts 1 and 2, send ts=1 then ts=2 (layer 1), each with 441 beats of addr 0..440 and data 0, then done_in -> finished=1, pass=1, ts_checked=2'b11.
REQ-022 Gold[0][17]=5, DUT sends addr 17 data 4 -> mm_valid for one cycle with mm_ts=1, mm_addr=17, mm_exp=5, mm_got=4; err_count=1; pass=0.
REQ-023 addr 3 sent twice within a 441-beat ts=1 frame -> dup_count=1, and the frame still closes after 441 beats.
REQ-024 Header ts=3, or header layer=2 -> oob_count=1, state stays HDR; spike addr 441 in CMP -> oob_count increments.
REQ-025 rst_n low during beat 200 of CMP -> all outputs 0, state IDLE; a following start plus a full clean run -> pass=1.
REQ-026 Force err_count to 16'hFFFF and inject one more mismatch -> err_count stays 16'hFFFF.

Source files
------------

// File: rtl/snn_chk_pkg.sv
// snn_chk_pkg
// Shared definitions for the spiking-network output checker.
// Holds the default parameter values used by snn_out_checker and
// snn_gold_mem, and the checker FSM state type.
// No ports (package).
package snn_chk_pkg;

  localparam int DEF_DATA_W   = 13;
  localparam int DEF_ADDR_W   = 12;
  localparam int DEF_DEPTH_R  = 21;
  localparam int DEF_NUM_TS   = 2;
  localparam int DEF_TS_W     = 2;
  localparam int DEF_LAYER_W  = 2;
  localparam int DEF_LAYER_ID = 1;
  localparam int DEF_CNT_W    = 16;

  // Checker phases: idle after reset, loading golden data, waiting for a
  // result header, comparing one timestep of spikes, and the final verdict.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    HDR   = 3'd2,
    CMP   = 3'd3,
    FINAL = 3'd4
  } chk_state_e;

endpackage

// File: rtl/snn_gold_mem.sv
// snn_gold_mem
// Golden reference storage: WORDS entries of DATA_W bits, one synchronous
// write port and one asynchronous (combinational) read port. Contents are
// deliberately never reset so a loaded golden image survives a rerun.
// Ports:
//   clk        single clock
//   wr_en_i    write strobe
//   wr_addr_i  write word index
//   wr_data_i  write data
//   rd_addr_i  read word index
//   rd_data_o  read data, valid in the same cycle as rd_addr_i
module snn_gold_mem
  import snn_chk_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int WORDS  = DEF_NUM_TS * DEF_DEPTH_R * DEF_DEPTH_R,
  parameter int AW     = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [WORDS];

  // Plain write-on-strobe array; there is no reset on purpose so that the
  // golden image outlives both rst_n and a new start.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/snn_out_checker.sv
// snn_out_checker
// Scoreboard for a spiking-network layer output. A golden image of NUM_TS
// timesteps (each DEPTH_R*DEPTH_R words) is loaded first; the DUT then sends
// a header per timestep followed by exactly N spike beats, each compared
// against the golden word at its address. Mismatches, duplicate addresses
// and out-of-range beats are counted, and a verdict is given once the DUT
// signals done.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   start                          clear counters and begin a golden load
//   gold_valid/ready/ts/addr/data  golden load beats
//   load_done                      golden load complete
//   hdr_valid/ready/ts/layer       per-timestep result header
//   spk_valid/ready/addr/data      DUT output spike beats
//   done_in                        DUT finished producing results
//   err_count/dup_count/oob_count  saturating error totals
//   ts_checked                     bit i set once timestep i+1 fully compared
//   mm_valid/ts/addr/exp/got       one-cycle mismatch report
//   finished, pass                 run over / run clean
module snn_out_checker
  import snn_chk_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DEPTH_R  = DEF_DEPTH_R,
  parameter int NUM_TS   = DEF_NUM_TS,
  parameter int TS_W     = DEF_TS_W,
  parameter int LAYER_W  = DEF_LAYER_W,
  parameter int LAYER_ID = DEF_LAYER_ID,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               gold_valid,
  output logic               gold_ready,
  input  logic [TS_W-1:0]    gold_ts,
  input  logic [ADDR_W-1:0]  gold_addr,
  input  logic [DATA_W-1:0]  gold_data,
  input  logic               load_done,
  input  logic               hdr_valid,
  output logic               hdr_ready,
  input  logic [TS_W-1:0]    hdr_ts,
  input  logic [LAYER_W-1:0] hdr_layer,
  input  logic               spk_valid,
  output logic               spk_ready,
  input  logic [ADDR_W-1:0]  spk_addr,
  input  logic [DATA_W-1:0]  spk_data,
  input  logic               done_in,
  output logic [CNT_W-1:0]   err_count,
  output logic [CNT_W-1:0]   dup_count,
  output logic [CNT_W-1:0]   oob_count,
  output logic [NUM_TS-1:0]  ts_checked,
  output logic               mm_valid,
  output logic [TS_W-1:0]    mm_ts,
  output logic [ADDR_W-1:0]  mm_addr,
  output logic [DATA_W-1:0]  mm_exp,
  output logic [DATA_W-1:0]  mm_got,
  output logic               finished,
  output logic               pass
);

  localparam int N       = DEPTH_R * DEPTH_R;
  localparam int WORDS   = NUM_TS * N;
  localparam int MEM_AW  = $clog2(WORDS);
  localparam int SEEN_AW = $clog2(N);
  localparam int BEAT_W  = $clog2(N + 1);

  chk_state_e state_q, state_d;

  logic [TS_W-1:0]   curTs_q, curTs_d;
  logic [N-1:0]      seen_q, seen_d;
  logic [BEAT_W-1:0] beatCnt_q, beatCnt_d;
  logic [CNT_W-1:0]  errCount_q, errCount_d;
  logic [CNT_W-1:0]  dupCount_q, dupCount_d;
  logic [CNT_W-1:0]  oobCount_q, oobCount_d;
  logic [NUM_TS-1:0] tsChecked_q, tsChecked_d;
  logic              mmValid_q, mmValid_d;
  logic [TS_W-1:0]   mmTs_q, mmTs_d;
  logic [ADDR_W-1:0] mmAddr_q, mmAddr_d;
  logic [DATA_W-1:0] mmExp_q, mmExp_d;
  logic [DATA_W-1:0] mmGot_q, mmGot_d;

  logic               startOk;
  logic               goldFire, goldKeep;
  logic               hdrFire, hdrOk;
  logic               spkFire, spkInRange, spkSeen, lastBeat;
  logic [SEEN_AW-1:0] spkIdx;
  logic [MEM_AW-1:0]  goldWrIdx, goldRdIdx;
  logic [DATA_W-1:0]  goldRd;

  function automatic logic tsInRange(input logic [TS_W-1:0] ts);
    return (32'(ts) >= 32'd1) && (32'(ts) <= 32'(NUM_TS));
  endfunction

  function automatic logic addrInRange(input logic [ADDR_W-1:0] addr);
    return 32'(addr) < 32'(N);
  endfunction

  // Timesteps are 1-based on the wire, so timestep t occupies words
  // (t-1)*N .. t*N-1 of the flat golden array.
  function automatic logic [MEM_AW-1:0] memIndex(input logic [TS_W-1:0]   ts,
                                                 input logic [ADDR_W-1:0] addr);
    logic [31:0] flat;
    flat = (32'(ts) - 32'd1) * 32'(N) + 32'(addr);
    return flat[MEM_AW-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign startOk    = start && ((state_q == IDLE) || (state_q == FINAL));
  assign goldFire   = gold_valid && gold_ready;
  assign goldKeep   = goldFire && tsInRange(gold_ts) && addrInRange(gold_addr);
  assign hdrFire    = hdr_valid && hdr_ready;
  assign hdrOk      = tsInRange(hdr_ts) && (hdr_layer == LAYER_W'(LAYER_ID));
  assign spkFire    = spk_valid && spk_ready;
  assign spkInRange = addrInRange(spk_addr);
  assign spkIdx     = spk_addr[SEEN_AW-1:0];
  assign spkSeen    = spkInRange && seen_q[spkIdx];
  assign lastBeat   = spkFire && (beatCnt_q == BEAT_W'(N - 1));
  assign goldWrIdx  = memIndex(gold_ts, gold_addr);
  assign goldRdIdx  = spkInRange ? memIndex(curTs_q, spk_addr) : '0;

  snn_gold_mem #(
    .DATA_W (DATA_W),
    .WORDS  (WORDS),
    .AW     (MEM_AW)
  ) u_gold_mem (
    .clk       (clk),
    .wr_en_i   (goldKeep),
    .wr_addr_i (goldWrIdx),
    .wr_data_i (gold_data),
    .rd_addr_i (goldRdIdx),
    .rd_data_o (goldRd)
  );

  // Next-state logic and the state-decoded outputs. Each ready is tied to
  // its own phase so a channel can only move data while the checker is
  // expecting it. A header beat takes precedence over done_in in HDR.
  always_comb begin
    state_d    = state_q;
    gold_ready = 1'b0;
    hdr_ready  = 1'b0;
    spk_ready  = 1'b0;
    finished   = 1'b0;
    pass       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        gold_ready = 1'b1;
        if (load_done) state_d = HDR;
      end
      HDR: begin
        hdr_ready = 1'b1;
        if (hdrFire) begin
          if (hdrOk) state_d = CMP;
        end else if (done_in) begin
          state_d = FINAL;
        end
      end
      CMP: begin
        spk_ready = 1'b1;
        if (lastBeat) state_d = HDR;
      end
      FINAL: begin
        finished = 1'b1;
        pass     = (errCount_q == '0) && (dupCount_q == '0) &&
                   (oobCount_q == '0) && (&tsChecked_q);
        if (start) state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath next-state: counters, seen bitmap, beat counter and the
  // mismatch report. Spike classification order matters: an out-of-range
  // address never touches the bitmap, and a duplicate is never compared,
  // so a repeated beat cannot add a second mismatch for the same address.
  // The mismatch report is a one-cycle pulse; its fields hold the last
  // reported mismatch until the next one.
  always_comb begin
    curTs_d     = curTs_q;
    seen_d      = seen_q;
    beatCnt_d   = beatCnt_q;
    errCount_d  = errCount_q;
    dupCount_d  = dupCount_q;
    oobCount_d  = oobCount_q;
    tsChecked_d = tsChecked_q;
    mmValid_d   = 1'b0;
    mmTs_d      = mmTs_q;
    mmAddr_d    = mmAddr_q;
    mmExp_d     = mmExp_q;
    mmGot_d     = mmGot_q;

    if (startOk) begin
      errCount_d  = '0;
      dupCount_d  = '0;
      oobCount_d  = '0;
      tsChecked_d = '0;
    end

    if (goldFire && !goldKeep) begin
      oobCount_d = satInc(oobCount_q);
    end

    if (hdrFire) begin
      if (hdrOk) begin
        seen_d    = '0;
        beatCnt_d = '0;
        curTs_d   = hdr_ts;
      end else begin
        oobCount_d = satInc(oobCount_q);
      end
    end

    if (spkFire) begin
      beatCnt_d = beatCnt_q + 1'b1;
      if (!spkInRange) begin
        oobCount_d = satInc(oobCount_q);
      end else if (spkSeen) begin
        dupCount_d = satInc(dupCount_q);
      end else begin
        seen_d[spkIdx] = 1'b1;
        if (spk_data != goldRd) begin
          errCount_d = satInc(errCount_q);
          mmValid_d  = 1'b1;
          mmTs_d     = curTs_q;
          mmAddr_d   = spk_addr;
          mmExp_d    = goldRd;
          mmGot_d    = spk_data;
        end
      end
      if (lastBeat) begin
        for (int t = 0; t < NUM_TS; t++) begin
          if (32'(curTs_q) == 32'(t + 1)) tsChecked_d[t] = 1'b1;
        end
      end
    end
  end

  // Datapath registers; everything except the golden memory is cleared by
  // reset, which also abandons any half-finished load or compare.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      curTs_q     <= '0;
      seen_q      <= '0;
      beatCnt_q   <= '0;
      errCount_q  <= '0;
      dupCount_q  <= '0;
      oobCount_q  <= '0;
      tsChecked_q <= '0;
      mmValid_q   <= 1'b0;
      mmTs_q      <= '0;
      mmAddr_q    <= '0;
      mmExp_q     <= '0;
      mmGot_q     <= '0;
    end else begin
      curTs_q     <= curTs_d;
      seen_q      <= seen_d;
      beatCnt_q   <= beatCnt_d;
      errCount_q  <= errCount_d;
      dupCount_q  <= dupCount_d;
      oobCount_q  <= oobCount_d;
      tsChecked_q <= tsChecked_d;
      mmValid_q   <= mmValid_d;
      mmTs_q      <= mmTs_d;
      mmAddr_q    <= mmAddr_d;
      mmExp_q     <= mmExp_d;
      mmGot_q     <= mmGot_d;
    end
  end

  assign err_count  = errCount_q;
  assign dup_count  = dupCount_q;
  assign oob_count  = oobCount_q;
  assign ts_checked = tsChecked_q;
  assign mm_valid   = mmValid_q;
  assign mm_ts      = mmTs_q;
  assign mm_addr    = mmAddr_q;
  assign mm_exp     = mmExp_q;
  assign mm_got     = mmGot_q;

endmodule

// File: tb/tb_snn_out_checker.sv
// tb_snn_out_checker
// Self-checking bench for snn_out_checker. A behavioural model (golden
// array, seen flags and plain integer counters) predicts every counter and
// mismatch report; header handling is driven from a vector table.
module tb_snn_out_checker;
  import snn_chk_pkg::*;

  localparam int DATA_W   = 13;
  localparam int ADDR_W   = 12;
  localparam int DEPTH_R  = 21;
  localparam int NUM_TS   = 2;
  localparam int TS_W     = 2;
  localparam int LAYER_W  = 2;
  localparam int LAYER_ID = 1;
  localparam int CNT_W    = 16;
  localparam int N        = DEPTH_R * DEPTH_R;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               gold_valid = 1'b0;
  logic               gold_ready;
  logic [TS_W-1:0]    gold_ts = '0;
  logic [ADDR_W-1:0]  gold_addr = '0;
  logic [DATA_W-1:0]  gold_data = '0;
  logic               load_done = 1'b0;
  logic               hdr_valid = 1'b0;
  logic               hdr_ready;
  logic [TS_W-1:0]    hdr_ts = '0;
  logic [LAYER_W-1:0] hdr_layer = '0;
  logic               spk_valid = 1'b0;
  logic               spk_ready;
  logic [ADDR_W-1:0]  spk_addr = '0;
  logic [DATA_W-1:0]  spk_data = '0;
  logic               done_in = 1'b0;
  logic [CNT_W-1:0]   err_count, dup_count, oob_count;
  logic [NUM_TS-1:0]  ts_checked;
  logic               mm_valid;
  logic [TS_W-1:0]    mm_ts;
  logic [ADDR_W-1:0]  mm_addr;
  logic [DATA_W-1:0]  mm_exp, mm_got;
  logic               finished, pass;

  snn_out_checker #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH_R(DEPTH_R), .NUM_TS(NUM_TS),
    .TS_W(TS_W), .LAYER_W(LAYER_W), .LAYER_ID(LAYER_ID), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .gold_valid(gold_valid), .gold_ready(gold_ready), .gold_ts(gold_ts),
    .gold_addr(gold_addr), .gold_data(gold_data), .load_done(load_done),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_ts(hdr_ts),
    .hdr_layer(hdr_layer), .spk_valid(spk_valid), .spk_ready(spk_ready),
    .spk_addr(spk_addr), .spk_data(spk_data), .done_in(done_in),
    .err_count(err_count), .dup_count(dup_count), .oob_count(oob_count),
    .ts_checked(ts_checked), .mm_valid(mm_valid), .mm_ts(mm_ts),
    .mm_addr(mm_addr), .mm_exp(mm_exp), .mm_got(mm_got),
    .finished(finished), .pass(pass)
  );

  // Free-running 10 ns clock; stimulus changes on the falling edge.
  always #5 clk = ~clk;

  // Watchdog so a stuck run still ends with a visible failure.
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  int checks = 0;
  int passes = 0;

  int mGold [NUM_TS][N];
  bit mSeen [N];
  int mErr, mDup, mOob, mCurTs, mBeats;
  bit [NUM_TS-1:0] mTsChk;

  typedef struct {
    int ts;
    int layer;
    bit expCmp;
    int expOobInc;
  } hdrVec_t;

  function automatic int sat(input int c);
    return (c >= CNT_MAX) ? CNT_MAX : c + 1;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, " err_count"}, err_count, mErr);
    checkOutput({tag, " dup_count"}, dup_count, mDup);
    checkOutput({tag, " oob_count"}, oob_count, mOob);
    checkOutput({tag, " ts_checked"}, ts_checked, mTsChk);
  endtask

  task automatic clearModelCounters();
    mErr = 0; mDup = 0; mOob = 0; mTsChk = '0;
  endtask

  task automatic doStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    clearModelCounters();
  endtask

  task automatic goldBeat(input int ts, input int addr, input int data, input bit done);
    gold_valid = 1'b1;
    gold_ts    = TS_W'(ts);
    gold_addr  = ADDR_W'(addr);
    gold_data  = DATA_W'(data);
    load_done  = done;
    @(negedge clk);
    gold_valid = 1'b0;
    load_done  = 1'b0;
    if (ts >= 1 && ts <= NUM_TS && addr < N) mGold[ts-1][addr] = data;
    else mOob = sat(mOob);
  endtask

  task automatic loadDoneOnly();
    load_done = 1'b1;
    @(negedge clk);
    load_done = 1'b0;
  endtask

  task automatic hdrBeat(input int ts, input int layer);
    hdr_valid = 1'b1;
    hdr_ts    = TS_W'(ts);
    hdr_layer = LAYER_W'(layer);
    @(negedge clk);
    hdr_valid = 1'b0;
    if (ts >= 1 && ts <= NUM_TS && layer == LAYER_ID) begin
      mCurTs = ts;
      mBeats = 0;
      foreach (mSeen[i]) mSeen[i] = 1'b0;
    end else begin
      mOob = sat(mOob);
    end
  endtask

  task automatic spkBeat(input int addr, input int data);
    bit expMm;
    int expV;
    expMm = 1'b0;
    expV  = 0;
    spk_valid = 1'b1;
    spk_addr  = ADDR_W'(addr);
    spk_data  = DATA_W'(data);
    @(negedge clk);
    spk_valid = 1'b0;
    mBeats++;
    if (addr >= N) mOob = sat(mOob);
    else if (mSeen[addr]) mDup = sat(mDup);
    else begin
      mSeen[addr] = 1'b1;
      expV = mGold[mCurTs-1][addr];
      if (data != expV) begin
        mErr  = sat(mErr);
        expMm = 1'b1;
      end
    end
    if (mBeats == N) mTsChk[mCurTs-1] = 1'b1;
    checkOutput("mm_valid", mm_valid, expMm);
    if (expMm) begin
      checkOutput("mm_ts", mm_ts, mCurTs);
      checkOutput("mm_addr", mm_addr, addr);
      checkOutput("mm_exp", mm_exp, expV);
      checkOutput("mm_got", mm_got, data);
      checkOutput("err_count at report", err_count, mErr);
    end
  endtask

  task automatic frameEnd(input string tag);
    checkOutput({tag, " hdr_ready after N beats"}, hdr_ready, 1);
    checkOutput({tag, " spk_ready after N beats"}, spk_ready, 0);
    @(negedge clk);
    checkOutput({tag, " mm_valid one-cycle"}, mm_valid, 0);
    checkCounters(tag);
  endtask

  task automatic cleanFrame(input int ts);
    hdrBeat(ts, LAYER_ID);
    checkOutput("spk_ready after header", spk_ready, 1);
    for (int i = 0; i < N; i++) spkBeat(i, mGold[ts-1][i]);
    frameEnd("clean frame");
  endtask

  task automatic randomFrame(input int ts);
    int r, a, d;
    hdrBeat(ts, LAYER_ID);
    checkOutput("spk_ready after header", spk_ready, 1);
    for (int i = 0; i < N; i++) begin
      r = int'($urandom_range(0, 99));
      a = i;
      if (r < 3) a = int'($urandom_range(N, 4095));
      else if (r < 7) a = int'($urandom_range(0, N - 1));
      if (a >= N || $urandom_range(0, 99) < 5) d = int'($urandom_range(0, 8191));
      else d = mGold[ts-1][a];
      spkBeat(a, d);
    end
    frameEnd("random frame");
  endtask

  task automatic doDone(input bit expPass);
    done_in = 1'b1;
    @(negedge clk);
    done_in = 1'b0;
    checkOutput("finished", finished, 1);
    checkOutput("pass", pass, expPass);
    checkCounters("final");
  endtask

  task automatic applyStimulus(input hdrVec_t v);
    int oobBefore;
    oobBefore = mOob;
    hdrBeat(v.ts, v.layer);
    checkOutput($sformatf("hdr ts=%0d layer=%0d oob_count", v.ts, v.layer),
                oob_count, oobBefore + v.expOobInc);
    checkOutput($sformatf("hdr ts=%0d layer=%0d spk_ready", v.ts, v.layer),
                spk_ready, v.expCmp);
    checkOutput($sformatf("hdr ts=%0d layer=%0d hdr_ready", v.ts, v.layer),
                hdr_ready, !v.expCmp);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " err_count"}, err_count, 0);
    checkOutput({tag, " dup_count"}, dup_count, 0);
    checkOutput({tag, " oob_count"}, oob_count, 0);
    checkOutput({tag, " ts_checked"}, ts_checked, 0);
    checkOutput({tag, " mm_valid"}, mm_valid, 0);
    checkOutput({tag, " mm_ts"}, mm_ts, 0);
    checkOutput({tag, " mm_addr"}, mm_addr, 0);
    checkOutput({tag, " mm_exp"}, mm_exp, 0);
    checkOutput({tag, " mm_got"}, mm_got, 0);
    checkOutput({tag, " finished"}, finished, 0);
    checkOutput({tag, " pass"}, pass, 0);
    checkOutput({tag, " gold_ready"}, gold_ready, 0);
    checkOutput({tag, " hdr_ready"}, hdr_ready, 0);
    checkOutput({tag, " spk_ready"}, spk_ready, 0);
  endtask

  // Main sequence: reset, clean all-zero run, random gold with header table
  // and a hand-built error frame, random frames, saturation, and resets
  // in the middle of a compare and a load.
  initial begin
    hdrVec_t hdrTab [6];
    int a, d;
    hdrTab[0] = '{ts: 3, layer: 1, expCmp: 1'b0, expOobInc: 1};
    hdrTab[1] = '{ts: 1, layer: 2, expCmp: 1'b0, expOobInc: 1};
    hdrTab[2] = '{ts: 0, layer: 1, expCmp: 1'b0, expOobInc: 1};
    hdrTab[3] = '{ts: 2, layer: 0, expCmp: 1'b0, expOobInc: 1};
    hdrTab[4] = '{ts: 2, layer: 3, expCmp: 1'b0, expOobInc: 1};
    hdrTab[5] = '{ts: 1, layer: 1, expCmp: 1'b1, expOobInc: 0};
    clearModelCounters();
    mCurTs = 1;
    mBeats = 0;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] all-zero golden, two clean timesteps");
    doStart();
    for (int t = 1; t <= NUM_TS; t++)
      for (int i = 0; i < N; i++)
        goldBeat(t, i, 0, (t == NUM_TS) && (i == N - 1));
    cleanFrame(1);
    cleanFrame(2);
    doDone(1'b1);
    checkOutput("clean ts_checked", ts_checked, 2'b11);

    $display("[TB] random golden load, out-of-range beats, header table");
    doStart();
    checkCounters("after start from FINAL");
    for (int t = 1; t <= NUM_TS; t++)
      for (int i = 0; i < N; i++)
        goldBeat(t, i, int'($urandom_range(0, 8191)), 1'b0);
    goldBeat(0, 5, 7, 1'b0);
    goldBeat(3, 5, 7, 1'b0);
    goldBeat(1, N, 7, 1'b0);
    goldBeat(1, 17, 5, 1'b1);
    checkOutput("load_done with beat hdr_ready", hdr_ready, 1);
    checkOutput("load_done with beat gold_ready", gold_ready, 0);
    checkOutput("gold oob_count", oob_count, 3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("start ignored hdr_ready", hdr_ready, 1);
    checkOutput("start ignored oob_count", oob_count, mOob);
    for (int k = 0; k < 6; k++) applyStimulus(hdrTab[k]);

    $display("[TB] hand-built frame: mismatch, duplicate, out-of-range");
    for (int i = 0; i < N; i++) begin
      a = i;
      if (i == N - 2) a = N;
      if (i == N - 1) a = 3;
      d = (a < N) ? mGold[0][a] : 0;
      if (a == 17) d = 4;
      spkBeat(a, d);
    end
    frameEnd("error frame");
    checkOutput("error frame err_count", err_count, 1);
    checkOutput("error frame dup_count", dup_count, 1);
    checkOutput("error frame ts_checked", ts_checked, 2'b01);

    $display("[TB] randomized frames");
    for (int f = 0; f < 4; f++) begin
      if ($urandom_range(0, 1) == 1) applyStimulus('{ts: 3, layer: LAYER_ID, expCmp: 1'b0, expOobInc: 1});
      randomFrame(int'($urandom_range(1, NUM_TS)));
    end
    doDone(1'b0);

    $display("[TB] error counter saturation");
    doStart();
    checkCounters("restart");
    loadDoneOnly();
    force dut.errCount_q = 16'hFFFF;
    @(negedge clk);
    release dut.errCount_q;
    mErr = CNT_MAX;
    checkOutput("err_count preset", err_count, 16'hFFFF);
    hdrBeat(1, LAYER_ID);
    for (int i = 0; i < N; i++) begin
      d = mGold[0][i];
      if (i == 17) d = d ^ 1;
      spkBeat(i, d);
    end
    frameEnd("saturation frame");
    checkOutput("err_count saturated", err_count, 16'hFFFF);

    $display("[TB] reset during compare, then during load");
    hdrBeat(2, LAYER_ID);
    for (int i = 0; i < 200; i++) spkBeat(i, mGold[1][i]);
    spk_valid = 1'b1;
    spk_addr  = ADDR_W'(200);
    spk_data  = DATA_W'(mGold[1][200] ^ 1);
    rst_n     = 1'b0;
    @(negedge clk);
    spk_valid = 1'b0;
    checkAllZero("reset mid-CMP");
    rst_n = 1'b1;
    clearModelCounters();
    @(negedge clk);
    doStart();
    checkOutput("load after reset gold_ready", gold_ready, 1);
    for (int i = 0; i < 3; i++) goldBeat(1, i, int'($urandom_range(0, 8191)), 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clearModelCounters();
    checkOutput("reset mid-LOAD gold_ready", gold_ready, 0);
    @(negedge clk);
    doStart();
    loadDoneOnly();
    cleanFrame(1);
    cleanFrame(2);
    doDone(1'b1);
    checkOutput("rerun ts_checked", ts_checked, 2'b11);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
